// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter that shares one single-port data memory between two requesters.
// Accesses are serialised IDLE -> ISSUE [-> RDWAIT -> RESP]; every output is a register.
module data_mem_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Index 0 is port A, index 1 is port B.
    logic [1:0]        req;
    logic [1:0]        we_in;
    logic [ADDR_W-1:0] addr_in  [2];
    logic [DATA_W-1:0] wdata_in [2];

    assign req         = {b_req, a_req};
    assign we_in       = {b_we, a_we};
    assign addr_in[0]  = a_addr;
    assign addr_in[1]  = b_addr;
    assign wdata_in[0] = a_wdata;
    assign wdata_in[1] = b_wdata;

    state_t            state_reg, state_next;
    logic              pri_b_reg, pri_b_next;
    logic              owner_reg, owner_next;
    logic              we_reg, we_next;
    logic              mem_wr_en_reg, mem_wr_en_next;
    logic              mem_rd_en_reg, mem_rd_en_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
    logic [1:0]        gnt_reg, gnt_next;
    logic [1:0]        rvalid_reg, rvalid_next;
    logic              busy_reg, busy_next;
    logic [DATA_W-1:0] rdata_reg [2];
    logic [1:0]        cap_en;
    logic              win_b;

    always_comb begin
        state_next     = state_reg;
        pri_b_next     = pri_b_reg;
        owner_next     = owner_reg;
        we_next        = we_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        mem_wr_en_next = 1'b0;
        mem_rd_en_next = 1'b0;
        gnt_next       = 2'b00;
        rvalid_next    = 2'b00;
        win_b          = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    // B wins when it is alone, or when both ask and B holds priority.
                    win_b                = req[1] & (~req[0] | pri_b_reg);
                    owner_next           = win_b;
                    pri_b_next           = ~win_b;
                    we_next              = we_in[win_b];
                    mem_addr_next        = addr_in[win_b];
                    mem_wdata_next       = wdata_in[win_b];
                    mem_wr_en_next       = we_in[win_b];
                    mem_rd_en_next       = ~we_in[win_b];
                    gnt_next[win_b]      = 1'b1;
                    state_next           = ISSUE;
                end
            end
            ISSUE:  state_next = we_reg ? IDLE : RDWAIT;
            RDWAIT: begin
                rvalid_next[owner_reg] = 1'b1;
                state_next             = RESP;
            end
            RESP:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            pri_b_reg     <= 1'b0;
            owner_reg     <= 1'b0;
            we_reg        <= 1'b0;
            mem_wr_en_reg <= 1'b0;
            mem_rd_en_reg <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            gnt_reg       <= 2'b00;
            rvalid_reg    <= 2'b00;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pri_b_reg     <= pri_b_next;
            owner_reg     <= owner_next;
            we_reg        <= we_next;
            mem_wr_en_reg <= mem_wr_en_next;
            mem_rd_en_reg <= mem_rd_en_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            gnt_reg       <= gnt_next;
            rvalid_reg    <= rvalid_next;
            busy_reg      <= busy_next;
        end
    end

    // Memory data is valid during RDWAIT; only the owning port's register loads it.
    assign cap_en = {owner_reg, ~owner_reg} & {2{state_reg == RDWAIT}};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rdata
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_reg[gi] <= '0;
                end else if (cap_en[gi]) begin
                    rdata_reg[gi] <= mem_rdata;
                end
            end
        end
    endgenerate

    assign a_gnt     = gnt_reg[0];
    assign b_gnt     = gnt_reg[1];
    assign a_rvalid  = rvalid_reg[0];
    assign b_rvalid  = rvalid_reg[1];
    assign a_rdata   = rdata_reg[0];
    assign b_rdata   = rdata_reg[1];
    assign mem_wr_en = mem_wr_en_reg;
    assign mem_rd_en = mem_rd_en_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign busy      = busy_reg;

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Two-requester arbiter that shares the single-port 64x16 data memory between the CPU core (port A) and a debug/DMA loader (port B).
- Sits between the requesters and the data memory's wr_en/rd_en/data/addr/rdata pins, replacing the direct core-to-RAM connection in the system top.
- Serialises accesses with a small FSM, round-robin priority and tagged read-data return.

Parameters:
- DATA_W, 16, data word width
- ADDR_W, 6, memory word-address width (64 words)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- a_req  in  1  port A access request; held with fields stable until a_gnt
- a_we  in  1  port A: 1 = write, 0 = read
- a_addr  in  ADDR_W  port A word address
- a_wdata  in  DATA_W  port A write data
- a_gnt  out  1  one-cycle pulse: port A request accepted
- a_rvalid  out  1  one-cycle pulse: a_rdata valid
- a_rdata  out  DATA_W  port A read data, held until next A read
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: port B, identical to port A
- mem_wr_en  out  1  memory write enable
- mem_rd_en  out  1  memory read enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_rd_en
- busy  out  1  high in every state except IDLE

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- All outputs are registered.
- Reset values: every output is 0, FSM is IDLE, pri_b = 0, owner = A.
- FSM states:
  - IDLE: sample requests. If any req is high, pick a winner, latch its we/addr/wdata and the owner tag, flip pri to the loser, and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE (1 cycle): drive mem_addr and mem_wdata. Assert mem_wr_en (we=1) or mem_rd_en (we=0). Pulse the winner's gnt. Go to IDLE for a write, RDWAIT for a read.
  - RDWAIT (1 cycle): enables are 0; capture mem_rdata into the owner's rdata. Go to RESP.
  - RESP (1 cycle): pulse the owner's rvalid. Go to IDLE.
- Arbitration:
  - Only one requester high: it wins.
  - Both high: pri_b = 0 selects A, pri_b = 1 selects B.
  - After any grant, pri_b = (winner == A).
- Timing, with request sampled in IDLE at cycle N:
  - Memory command and gnt appear in cycle N+1.
  - Write completes at the N+1 edge.
  - Read: rdata is loaded at the end of N+2; rvalid is high in N+3 with rdata already valid.
- Throughput: one write per 2 cycles, one read per 4 cycles. Requesters may re-raise req in the cycle after gnt.
- The requester must drop or change req the cycle after gnt. A still-high req is treated as a new request on the next IDLE.
- mem_wr_en and mem_rd_en are never high together, and never high outside ISSUE.
- mem_addr and mem_wdata hold their last values outside ISSUE.
- Non-owner rdata is never modified. Non-owner rvalid and gnt stay 0.
- Requests arriving outside IDLE are ignored until IDLE. There is no queueing and no starvation: a waiting requester wins the next arbitration.
- Reset mid-operation (any state): return to IDLE with all outputs 0 on the next edge.
  - A pending read is dropped and no rvalid is issued.
  - A write in ISSUE on the reset edge is not guaranteed to complete.
- Address is passed through unmodified. Width mismatches are the integrator's responsibility.

Test Plan:
- Reset, then A writes 0xBEEF to addr 0x05 -> a_gnt and mem_wr_en pulse 1 cycle later with mem_addr=0x05, mem_wdata=0xBEEF. No b_gnt, no rvalid. busy=1 for exactly 1 cycle.
- A reads addr 0x05 (memory returns 0xBEEF) -> a_gnt at N+1, mem_rd_en only at N+1, a_rvalid pulse at N+3 with a_rdata=0xBEEF. b_rdata stays 0.
- a_req and b_req raised together right after reset, both held -> A granted first, then B, then A, alternating. No grant is ever issued to both ports in the same cycle.
- B write 0x1234 to 0x3F, then A read of 0x3F requested while B is in ISSUE -> A is accepted only after return to IDLE and reads 0x1234.
- rst asserted during RDWAIT of a B read -> next cycle all outputs 0 and FSM in IDLE. No b_rvalid ever appears. A following A request is served normally.
- Random mixed traffic (1000 ops) against a reference memory model -> every read returns the last written value. Every req eventually sees gnt within 5 cycles of IDLE.
